// File: rtl/ws2812_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx_if
// Purpose  : Decoded-pixel output bundle of the WS2812 receiver.
//            master : the receiver, which drives every signal
//            slave  : the consumer, which observes every signal
// Signals  : address     index of the pixel being presented
//            red/green/blue  decoded colour bytes
//            pixel_valid one-cycle strobe, address/colour valid
//            frame_done  one-cycle strobe at latch-gap detection
//            overflow    sticky, more pixels than the chain length
// Revision : 1.0 - initial release
// ============================================================================
interface ws2812_rx_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              pixel_valid;
  logic              frame_done;
  logic              overflow;

  modport master (output address, red, green, blue, pixel_valid, frame_done, overflow);
  modport slave  (input  address, red, green, blue, pixel_valid, frame_done, overflow);
endinterface
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx
// Purpose  : WS2812 serial pixel receiver. Measures high-pulse widths on DI,
//            decodes 24-bit GRB pixels (MSB first), presents them as RGB
//            bytes with an index and a strobe, and flags the latch gap.
// Ports    : clk    system clock
//            reset  asynchronous, active-high reset
//            DI     serial data in (asynchronous to clk)
//            px     decoded-pixel bundle (ws2812_rx_if.master)
//            DO     chain pass-through (only with WS2812_RX_FORWARD_EN)
// Options  : WS2812_RX_FORWARD_EN - forward pixels beyond NUM_LEDS on DO
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 48000000,
  parameter int T_THRESH_NS  = 600,
  parameter int T_GLITCH_NS  = 100,
  parameter int T_LATCH_US   = 50
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   DI,
  ws2812_rx_if.master px
`ifdef WS2812_RX_FORWARD_EN
  ,
  output logic        DO
`endif
);

  localparam int ADDR_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W      = $clog2(NUM_LEDS + 1);
  localparam int THRESH_CYC = SYSTEM_CLOCK / 1000000 * T_THRESH_NS / 1000;
  localparam int GLITCH_CYC = SYSTEM_CLOCK / 1000000 * T_GLITCH_NS / 1000;
  localparam int LATCH_CYC  = SYSTEM_CLOCK / 1000000 * T_LATCH_US;

  localparam logic [15:0]      THRESH_C = 16'(THRESH_CYC);
  localparam logic [15:0]      GLITCH_C = 16'(GLITCH_CYC);
  localparam logic [15:0]      LATCH_C  = 16'(LATCH_CYC);
  localparam logic [CNT_W-1:0] LEDS_C   = CNT_W'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t state, state_next;

  logic              sync_meta, sync_q, edge_q;
  logic              rise, fall;
  logic [15:0]       width;
  logic [23:0]       shreg;
  logic [4:0]        bit_cnt;
  logic [CNT_W-1:0]  pix_cnt;
  logic              pend;       // full pixel captured, present it next cycle
  logic              bits_seen;  // any bit accepted since the last gap
  logic              accept, gap, bit_val;

  logic [ADDR_W-1:0] address;
  logic [7:0]        red, green, blue;
  logic              pixel_valid, frame_done, overflow;

  assign rise    = sync_q & ~edge_q;
  assign fall    = ~sync_q & edge_q;
  assign bit_val = (width >= THRESH_C);

  // Synchronizer plus edge-detect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      sync_meta <= DI;
      sync_q    <= sync_meta;
      edge_q    <= sync_q;
    end
  end

  // Pulse/gap width: restarts on each edge, saturates instead of wrapping so
  // a stuck line still reads as a long pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width <= 16'd0;
    end else if (rise | fall) begin
      width <= 16'd0;
    end else if (width != 16'hFFFF) begin
      width <= width + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    gap        = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          state_next = LOW;
          accept     = (width >= GLITCH_C);
        end
      end
      LOW: begin
        // The gap takes priority over a coincident rising edge: the frame
        // closes first and the new pulse is still measured.
        if (width >= LATCH_C) begin
          gap        = 1'b1;
          state_next = rise ? HIGH : IDLE;
        end else if (rise) begin
          state_next = HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= 24'd0;
      bit_cnt     <= 5'd0;
      pix_cnt     <= '0;
      pend        <= 1'b0;
      bits_seen   <= 1'b0;
      address     <= '0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (gap) begin
        shreg      <= 24'd0;
        bit_cnt    <= 5'd0;
        pix_cnt    <= '0;
        pend       <= 1'b0;
        bits_seen  <= 1'b0;
        frame_done <= bits_seen;
        overflow   <= 1'b0;
      end else begin
        if (accept) begin
          shreg     <= {shreg[22:0], bit_val};
          bits_seen <= 1'b1;
          if (bit_cnt == 5'd23) begin
            bit_cnt <= 5'd0;
            pend    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        if (pend) begin
          pend <= 1'b0;
          if (pix_cnt != LEDS_C) begin
            // Wire order is G, R, B.
            green       <= shreg[23:16];
            red         <= shreg[15:8];
            blue        <= shreg[7:0];
            address     <= pix_cnt[ADDR_W-1:0];
            pixel_valid <= 1'b1;
            pix_cnt     <= pix_cnt + CNT_W'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign px.address     = address;
  assign px.red         = red;
  assign px.green       = green;
  assign px.blue        = blue;
  assign px.pixel_valid = pixel_valid;
  assign px.frame_done  = frame_done;
  assign px.overflow    = overflow;

`ifdef WS2812_RX_FORWARD_EN
  // Forwarding opens once this chain segment is full and closes at the gap.
  logic fwd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fwd_en <= 1'b0;
    else       fwd_en <= (pix_cnt == LEDS_C) && !gap;
  end

  assign DO = fwd_en & edge_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ws2812_rx
// Purpose  : Self-checking bench for ws2812_rx. Drives WS2812 waveforms on DI;
//            expected pixels are queued as they are sent and compared when
//            pixel_valid strobes.
// Options  : WS2812_RX_FORWARD_EN - also checks the DO pass-through
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_rx;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic DI;
`ifdef WS2812_RX_FORWARD_EN
  logic DO;
  logic fwd_exp = 1'b0;
`endif

  int   errors  = 0;
  int   checks  = 0;
  int   strobes = 0;
  int   fd_cnt  = 0;
  int   exp_pix = 0;
  exp_t q[$];

  ws2812_rx_if #(.ADDR_W(3)) ifc ();

  ws2812_rx dut (
    .clk   (clk),
    .reset (reset),
    .DI    (DI),
    .px    (ifc)
`ifdef WS2812_RX_FORWARD_EN
    ,
    .DO    (DO)
`endif
  );

  always #10.417 clk = ~clk;

  // Scoreboard side: compare each strobe against the oldest queued pixel.
  always @(negedge clk) begin
    if (ifc.frame_done) fd_cnt++;
    if (ifc.pixel_valid) begin
      exp_t e;
      strobes++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got a=%0d g=%h r=%h b=%h, required no strobe",
                 ifc.address, ifc.green, ifc.red, ifc.blue);
      end else begin
        e = q.pop_front();
        if ({ifc.address, ifc.green, ifc.red, ifc.blue} !== e) begin
          errors++;
          $display("FAIL pixel: got a=%0d g=%h r=%h b=%h, required a=%0d g=%h r=%h b=%h",
                   ifc.address, ifc.green, ifc.red, ifc.blue, e.a, e.g, e.r, e.b);
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic glitch);
    int hi;
    int lo;
    hi = b ? 800 : 400;
    lo = b ? 450 : 850;
    DI = 1'b1;
    #100;
`ifdef WS2812_RX_FORWARD_EN
    checks++;
    if (DO !== fwd_exp) begin
      errors++;
      $display("FAIL do_high: got %b, required %b", DO, fwd_exp);
    end
`endif
    #(hi - 100);
    DI = 1'b0;
    if (glitch) begin
      #200;
      DI = 1'b1;
      #40;
      DI = 1'b0;
      #(lo - 240);
    end else begin
      #100;
`ifdef WS2812_RX_FORWARD_EN
      checks++;
      if (DO !== 1'b0) begin
        errors++;
        $display("FAIL do_low: got %b, required 0", DO);
      end
`endif
      #(lo - 100);
    end
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r,
                            input logic [7:0] b, input int glitch_idx);
    logic [23:0] d;
    d = {g, r, b};
    if (exp_pix < 8) q.push_back({exp_pix[2:0], g, r, b});
`ifdef WS2812_RX_FORWARD_EN
    fwd_exp = (exp_pix >= 8);
`endif
    exp_pix++;
    for (int i = 23; i >= 0; i--) send_bit(d[i], (23 - i) == glitch_idx);
  endtask

  task automatic send_gap();
    DI = 1'b0;
    #55000;
    exp_pix = 0;
`ifdef WS2812_RX_FORWARD_EN
    fwd_exp = 1'b0;
`endif
  endtask

  task automatic check_frame(input string name, input int st0, input int nst,
                             input int fd0, input int nfd);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d pending, required 0", name, q.size());
    end
    checks++;
    if (strobes - st0 != nst) begin
      errors++;
      $display("FAIL %s_strobes: got %0d, required %0d", name, strobes - st0, nst);
    end
    checks++;
    if (fd_cnt - fd0 != nfd) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d, required %0d", name, fd_cnt - fd0, nfd);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({ifc.address, ifc.red, ifc.green, ifc.blue,
         ifc.pixel_valid, ifc.frame_done, ifc.overflow} !== 30'd0) begin
      errors++;
      $display("FAIL %s: got a=%0d r=%h g=%h b=%h pv=%b fd=%b ov=%b, required all 0",
               name, ifc.address, ifc.red, ifc.green, ifc.blue,
               ifc.pixel_valid, ifc.frame_done, ifc.overflow);
    end
  endtask

  task automatic test_reset();
    DI    = 1'b0;
    reset = 1'b1;
    #100;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
    #200;
  endtask

  task automatic test_single_pixel();
    int st0 = strobes;
    int fd0 = fd_cnt;
    send_pixel(8'h12, 8'h34, 8'h56, -1);
    send_gap();
    check_frame("single", st0, 1, fd0, 1);
  endtask

  task automatic test_full_frame();
    int st0 = strobes;
    int fd0 = fd_cnt;
    for (int i = 0; i < 8; i++)
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), -1);
    #200;
    checks++;
    if (ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_overflow: got %b, required 0", ifc.overflow);
    end
    send_gap();
    check_frame("full", st0, 8, fd0, 1);
  endtask

  task automatic test_overflow();
    int st0 = strobes;
    int fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) send_pixel(8'(i * 17), 8'(255 - i), 8'(i), -1);
    #200;
    checks++;
    if (ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: got %b, required 0", ifc.overflow);
    end
    send_pixel(8'hAA, 8'hBB, 8'hCC, -1);
    #200;
    checks++;
    if (ifc.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_9th: got %b, required 1", ifc.overflow);
    end
    send_gap();
    checks++;
    if (ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got %b, required 0", ifc.overflow);
    end
    check_frame("ovf", st0, 8, fd0, 1);
  endtask

  task automatic test_fragment();
    int st0 = strobes;
    int fd0 = fd_cnt;
    for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
    send_gap();
    check_frame("fragment", st0, 0, fd0, 1);
    st0 = strobes;
    fd0 = fd_cnt;
    send_pixel(8'hFF, 8'hFF, 8'hFF, -1);
    send_gap();
    check_frame("after_fragment", st0, 1, fd0, 1);
  endtask

  task automatic test_glitch();
    int st0 = strobes;
    int fd0 = fd_cnt;
    send_pixel(8'hA5, 8'h3C, 8'h81, 5);
    send_gap();
    check_frame("glitch", st0, 1, fd0, 1);
  endtask

  task automatic test_mid_reset();
    int st0 = strobes;
    int fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) send_pixel(8'h40 + 8'(i), 8'h50, 8'h60, -1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    DI = 1'b1;
    #300;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    DI = 1'b0;
    exp_pix = 0;
    check_frame("pre_reset", st0, 3, fd0, 0);
    #100;
    @(negedge clk);
    reset = 1'b0;
    #300;
    st0 = strobes;
    fd0 = fd_cnt;
    send_pixel(8'h0F, 8'hF0, 8'h5A, -1);
    send_gap();
    check_frame("post_reset", st0, 1, fd0, 1);
  endtask

`ifdef WS2812_RX_FORWARD_EN
  task automatic test_forward();
    int st0 = strobes;
    int fd0 = fd_cnt;
    for (int i = 0; i < 10; i++)
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), -1);
    send_gap();
    checks++;
    if (DO !== 1'b0) begin
      errors++;
      $display("FAIL do_after_gap: got %b, required 0", DO);
    end
    check_frame("forward", st0, 8, fd0, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_overflow();
    test_fragment();
    test_glitch();
    test_mid_reset();
`ifdef WS2812_RX_FORWARD_EN
    test_forward();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receives a WS2812 serial pixel stream on a single data input and recovers 24-bit pixels.
- Sits at the far end of a ws2812c-driven chain or in loopback benches, emulating a chain of NUM_LEDS pixels.
- Presents each decoded pixel as separate red/green/blue bytes, with its pixel index and a one-cycle strobe.
- Detects the latch (reset) gap and reports end of frame.

Parameters:
- NUM_LEDS, 8, number of pixels this block consumes per frame.
- SYSTEM_CLOCK, 48000000, clk frequency in Hz.
- T_THRESH_NS, 600, high-pulse width at or above which a bit decodes as 1.
- T_GLITCH_NS, 100, high pulses shorter than this are discarded.
- T_LATCH_US, 50, low time at or above which the frame ends.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- DI  input  1  WS2812 serial data in, asynchronous to clk
- address  output  $clog2(NUM_LEDS)  index of the pixel currently presented
- red  output  8  decoded red byte
- green  output  8  decoded green byte
- blue  output  8  decoded blue byte
- pixel_valid  output  1  one-cycle strobe; address/red/green/blue valid
- frame_done  output  1  one-cycle strobe at latch-gap detection
- overflow  output  1  sticky; more than NUM_LEDS pixels were seen this frame

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
- Derived cycle constants, integer arithmetic, computed as SYSTEM_CLOCK/1000000*T/1000 for ns parameters and SYSTEM_CLOCK/1000000*T for µs parameters:
  - THRESH_CYC = 28 at defaults.
  - GLITCH_CYC = 4 at defaults.
  - LATCH_CYC = 2400 at defaults.
- DI passes through a 2-flop synchronizer, followed by one edge-detect register.
- Width counter:
  - 16 bits, saturating at 0xFFFF, never wraps.
  - Cleared on every synchronized edge.
- States:
  - IDLE: waiting for the first rising edge.
  - HIGH: measuring pulse width.
  - LOW: measuring gap.
- Transitions:
  - IDLE -> HIGH on rising edge.
  - HIGH -> LOW on falling edge.
  - LOW -> HIGH on rising edge.
  - LOW -> IDLE when the low count reaches LATCH_CYC.
- Falling edge in HIGH:
  - Width < GLITCH_CYC: pulse ignored, bit counter unchanged.
  - Otherwise: bit = (width >= THRESH_CYC); shift into a 24-bit register, MSB first.
  - Wire order is G[7:0], R[7:0], B[7:0].
- Pixel completion (24th bit):
  - If the pixel count is below NUM_LEDS: on the next clk, load red/green/blue and address = pixel count, pulse pixel_valid for 1 cycle, then increment the pixel count.
  - If the pixel count equals NUM_LEDS: no strobe, set overflow, pixel count holds.
  - The bit counter returns to 0 in both cases.
- Latency: pixel_valid rises 4 clk after the 24th falling edge reaches the DI pin (2 sync + 1 edge detect + 1 output register).
- Latch gap (LOW -> IDLE):
  - Pulse frame_done for 1 cycle only if at least one bit was accepted since the last gap.
  - Pixel count, bit counter and shift register clear.
  - An incomplete pixel is discarded with no strobe.
  - overflow clears on the same cycle frame_done pulses.
- Held outputs: red/green/blue/address keep their last values between strobes.
- A rising edge on the exact cycle the low count reaches LATCH_CYC counts as a gap: frame ends first, then HIGH is entered.
- DI stuck high: width saturates, and the eventual falling edge decodes a 1.
- Reset, including mid-pixel:
  - State IDLE.
  - All counters 0, synchronizer 0.
  - red/green/blue/address 0.
  - pixel_valid, frame_done, overflow 0.

Optional Feature:
- Macro: WS2812_RX_FORWARD_EN.
- Defined: adds output port DO (1 bit), chain pass-through.
  - DO = synchronized DI delayed by the edge-detect register (2-3 clk total) while the pixel count equals NUM_LEDS; DO = 0 otherwise.
  - The enable is registered and drops at the latch gap, so a downstream receiver sees only pixels NUM_LEDS+1 onward.
  - Pixels forwarded on DO still set overflow.
- Undefined: no DO port and no forwarding logic.

Test Plan:
- Single pixel with bits G=0x12, R=0x34, B=0x56, at 400ns/850ns for 0 and 800ns/450ns for 1 -> one pixel_valid with address 0, red 0x34, green 0x12, blue 0x56.
- 8 pixels then 60us low -> 8 strobes with address 0..7 in order, exactly one frame_done, overflow 0.
- 9 pixels then gap -> 8 strobes, overflow 1 after the 9th pixel; overflow returns to 0 with frame_done.
- 10 bits then gap, then a full pixel 0xFFFFFF -> no strobe for the fragment, one frame_done, then a strobe with address 0 and all channels 0xFF.
- 40ns high glitch between bits 5 and 6 -> ignored; pixel decodes unchanged.
- Reset asserted mid-pixel 3 -> all outputs 0 immediately; next frame starts at address 0.
- WS2812_RX_FORWARD_EN, 10 pixels -> DO stays low for pixels 0-7 and replicates pixels 8-9 waveforms, within 3 clk delay; DO goes low after the gap.
